rcvr_arbiter: RTL and testbench

- Round-robin read controller for N serial frame receivers (header 8'hA5 + 8-bit body; each exposes ready/overrun/data_out and takes a reading input).
- Selects one ready channel, captures its byte and overrun flag, and pulses that channel's reading for one cycle.
- Presents the byte on one valid/ready output stream tagged with the channel index.
- Sits between the receiver bank and the downstream byte consumer.

---
 rtl/rcvr_pkg.sv | 28 ++
 rtl/rcvr_arbiter_rr_pick.sv | 32 +++
 rtl/rcvr_arbiter.sv | 111 +++++++++++
 tb/tb_rcvr_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rcvr_pkg.sv
// rcvr_pkg: definitions shared by the serial frame receivers, their
// arbiters and the benches around them.
//   arb_state_e  - read-controller state encoding (ST_IDLE / ST_HOLD)
//   HDR_BYTE     - frame header byte
//   BODY_LEN     - frame body length in bits
//   ch_width()   - channel-index width for a given channel count
package rcvr_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam int         BODY_LEN = 8;

  // Equal to $clog2(n) for n >= 2. Never returns less than 1, so a
  // single-channel index still has a legal width.
  function automatic int ch_width(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 8; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/rcvr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req         in  N  request vector
//   ptr         in  W  highest-priority index (must be < N)
//   grant_valid out 1  some request is set
//   grant_idx   out W  first set request at or after ptr, wrapping mod N
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_idx
);

  int j;

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 0; i < N; i++) begin
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/rcvr_arbiter.sv
// rcvr_arbiter: round-robin read controller for a bank of serial frame
// receivers. Picks one ready+enabled channel, captures its byte and overrun
// flag, pulses that channel's reading for one cycle and offers the byte
// downstream on a valid/ready stream tagged with the channel index.
//
// Handshake: out_valid stays high and out_data/out_chan/out_ovr stay stable
// until out_valid && out_ready is sampled at a rising edge; that edge is the
// transfer. out_ready while out_valid is low is ignored.
//
// Ports:
//   clock, reset (sync, active low)
//   ch_enable/ch_ready/ch_overrun [N_CH]   receiver side inputs
//   ch_data [N_CH*DATA_W]                  channel k at [k*DATA_W +: DATA_W]
//   ch_reading [N_CH]                      one-hot one-cycle read acknowledge
//   out_valid/out_ready/out_data/out_chan/out_ovr   downstream stream
//   ovr_status [N_CH]                      sticky overrun record
//   ovr_clear [N_CH]                       level clear for ovr_status
//   state_dbg                              current controller state
module rcvr_arbiter
  import rcvr_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 8,
  localparam int CH_W   = ch_width(N_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ch_enable,
  input  logic [N_CH-1:0]          ch_ready,
  input  logic [N_CH-1:0]          ch_overrun,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  output logic [N_CH-1:0]          ch_reading,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_ovr,
  output logic [N_CH-1:0]          ovr_status,
  input  logic [N_CH-1:0]          ovr_clear,
  output arb_state_e               state_dbg
);

  arb_state_e       state, state_nxt;
  logic [CH_W-1:0]  rr_ptr;
  logic [N_CH-1:0]  eligible;
  logic             grant_valid;
  logic [CH_W-1:0]  grant_idx;
  logic [N_CH-1:0]  grant_onehot;
  logic             take;
  logic [N_CH-1:0]  ovr_set;

  assign eligible     = ch_ready & ch_enable;
  assign grant_onehot = {{(N_CH-1){1'b0}}, 1'b1} << grant_idx;

  rr_pick #(.N(N_CH), .W(CH_W)) u_pick (
    .req         (eligible),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          take      = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Live overrun on an enabled channel is recorded even without a grant;
  // the grant term covers the captured flag. Set beats clear.
  assign ovr_set = (ch_overrun & ch_enable) |
                   (take ? (grant_onehot & ch_overrun) : '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      ch_reading <= '0;
      out_data   <= '0;
      out_chan   <= '0;
      out_ovr    <= 1'b0;
      ovr_status <= '0;
    end else begin
      state      <= state_nxt;
      ovr_status <= (ovr_status & ~ovr_clear) | ovr_set;
      // Reading is high only in the first HOLD cycle; IDLE is not re-entered
      // before the receiver has seen it, so a byte is never granted twice.
      ch_reading <= take ? grant_onehot : '0;
      if (take) begin
        out_data <= ch_data[int'(grant_idx)*DATA_W +: DATA_W];
        out_chan <= grant_idx;
        out_ovr  <= ch_overrun[grant_idx];
        rr_ptr   <= (grant_idx == CH_W'(N_CH-1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign out_valid = (state == ST_HOLD);
  assign state_dbg = state;

endmodule

// File: tb/tb_rcvr_arbiter.sv
module tb_rcvr_arbiter;
  import rcvr_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  ch_enable, ch_ready, ch_overrun, ch_reading;
  logic [31:0] ch_data;
  logic        out_valid, out_ready, out_ovr;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic [3:0]  ovr_status, ovr_clear;
  arb_state_e  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  rcvr_arbiter #(.N_CH(4), .DATA_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .ch_enable  (ch_enable),
    .ch_ready   (ch_ready),
    .ch_overrun (ch_overrun),
    .ch_data    (ch_data),
    .ch_reading (ch_reading),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_chan   (out_chan),
    .out_ovr    (out_ovr),
    .ovr_status (ovr_status),
    .ovr_clear  (ovr_clear),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until a reading pulse appears, at most 8 cycles.
  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick();
      if (ch_reading != 4'b0) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ch_enable = 4'hF; ch_ready = 4'hF; ch_overrun = 4'h0;
    ch_data = 32'h0; out_ready = 1'b0; ovr_clear = 4'h0;
    tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (ch_reading !== 4'h0) begin bad++; $display("FAIL reset_reading: got %b want 0000", ch_reading); end
    total++; if ({out_data, out_chan, out_ovr} !== 11'h0) begin bad++; $display("FAIL reset_out: got %h/%0d/%b want 0", out_data, out_chan, out_ovr); end
    total++; if (ovr_status !== 4'h0) begin bad++; $display("FAIL reset_ovr: got %b want 0000", ovr_status); end
    total++; if (state_dbg !== ST_IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    ch_ready = 4'h0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    ch_ready = 4'b0100; ch_data = 32'h003C_0000; out_ready = 1'b1;
    wait_grant(ok);
    total++; if (!ok) begin bad++; $display("FAIL single_timeout: got no reading want pulse"); end
    total++; if (ch_reading !== 4'b0100) begin bad++; $display("FAIL single_reading: got %b want 0100", ch_reading); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h3C || out_chan !== 2'd2 || out_ovr !== 1'b0)
      begin bad++; $display("FAIL single_out: got v=%b d=%h c=%0d o=%b want v=1 d=3c c=2 o=0", out_valid, out_data, out_chan, out_ovr); end
    ch_ready = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0 || ch_reading !== 4'h0) begin bad++; $display("FAIL single_done: got v=%b r=%b want v=0 r=0000", out_valid, ch_reading); end
    // rr_ptr is now 3: with channels 0 and 3 ready, channel 3 wins.
    ch_ready = 4'b1001; ch_data = 32'hAA00_00BB;
    wait_grant(ok);
    total++; if (!ok || out_chan !== 2'd3 || out_data !== 8'hAA) begin bad++; $display("FAIL single_rrptr: got c=%0d d=%h want c=3 d=aa", out_chan, out_data); end
    ch_ready = 4'b0000;
    tick();
  endtask

  task automatic test_all_four();
    int pulses;
    logic [1:0] e;
    ch_ready = 4'hF; ch_data = 32'h1312_1110; out_ready = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ch_reading != 4'h0) begin
        pulses++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL all4_extra: got reading %b want none", ch_reading);
        end else begin
          e = exp_q.pop_front();
          if (ch_reading !== (4'b1 << e) || out_chan !== e || out_data !== (8'h10 + 8'(e)))
            begin bad++; $display("FAIL all4_grant: got r=%b c=%0d d=%h want c=%0d d=%h", ch_reading, out_chan, out_data, e, 8'h10 + 8'(e)); end
        end
        ch_ready = ch_ready & ~ch_reading;
      end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL all4_count: got %0d want 4", pulses); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    ch_ready = 4'b0010; ch_data = 32'h0000_5A00; out_ready = 1'b0;
    wait_grant(ok);
    total++; if (!ok || out_chan !== 2'd1 || out_data !== 8'h5A) begin bad++; $display("FAIL bp_grant: got c=%0d d=%h want c=1 d=5a", out_chan, out_data); end
    ch_ready = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h5A || out_chan !== 2'd1 || ch_reading !== 4'h0)
        begin bad++; $display("FAIL bp_hold: cycle %0d got v=%b d=%h c=%0d r=%b want v=1 d=5a c=1 r=0000", c, out_valid, out_data, out_chan, ch_reading); end
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got %b want 0", out_valid); end
    tick();
    total++; if (ch_reading !== 4'h0 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_regrant: got r=%b v=%b want 0", ch_reading, out_valid); end
  endtask

  task automatic test_overrun();
    bit ok;
    // rr_ptr is 2 here; only channel 3 is ready.
    ch_ready = 4'b1000; ch_overrun = 4'b1000; ch_data = 32'hFF00_0000; out_ready = 1'b1;
    wait_grant(ok);
    total++; if (!ok || out_chan !== 2'd3 || out_data !== 8'hFF || out_ovr !== 1'b1)
      begin bad++; $display("FAIL ovr_grant: got c=%0d d=%h o=%b want c=3 d=ff o=1", out_chan, out_data, out_ovr); end
    total++; if (ovr_status !== 4'b1000) begin bad++; $display("FAIL ovr_status: got %b want 1000", ovr_status); end
    ch_ready = 4'b0000; ovr_clear = 4'b1000;
    tick();
    total++; if (ovr_status !== 4'b1000) begin bad++; $display("FAIL ovr_setwins: got %b want 1000", ovr_status); end
    ch_overrun = 4'b0000;
    tick();
    total++; if (ovr_status !== 4'b0000) begin bad++; $display("FAIL ovr_clear: got %b want 0000", ovr_status); end
    ovr_clear = 4'b0000;
    tick();
  endtask

  task automatic test_enable_mask();
    int pulses;
    logic [1:0] e;
    ch_enable = 4'b1011; ch_ready = 4'hF; ch_data = 32'h4342_4140; out_ready = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd3};
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (ch_reading != 4'h0) begin
        pulses++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL mask_extra: got reading %b want none", ch_reading);
        end else begin
          e = exp_q.pop_front();
          if (ch_reading !== (4'b1 << e) || out_chan !== e || out_data !== (8'h40 + 8'(e)))
            begin bad++; $display("FAIL mask_grant: got r=%b c=%0d d=%h want c=%0d d=%h", ch_reading, out_chan, out_data, e, 8'h40 + 8'(e)); end
        end
        ch_ready = ch_ready & ~ch_reading;
      end
    end
    total++; if (pulses != 3) begin bad++; $display("FAIL mask_count: got %0d want 3", pulses); end
    total++; if (ch_ready !== 4'b0100) begin bad++; $display("FAIL mask_ch2: ready left %b want 0100", ch_ready); end
    ch_ready = 4'h0; ch_enable = 4'hF;
    tick();
  endtask

  task automatic test_reset_mid_hold();
    bit ok;
    ch_overrun = 4'b0001;
    tick();
    ch_overrun = 4'b0000;
    total++; if (ovr_status !== 4'b0001) begin bad++; $display("FAIL rst_ovrpre: got %b want 0001", ovr_status); end
    ch_ready = 4'b0010; ch_data = 32'h0000_7700; out_ready = 1'b0;
    wait_grant(ok);
    total++; if (!ok || out_chan !== 2'd1) begin bad++; $display("FAIL rst_grant: got c=%0d want 1", out_chan); end
    ch_ready = 4'hF; ch_data = 32'h8483_8281;
    reset = 1'b0;
    tick();
    total++; if (out_valid !== 1'b0 || ch_reading !== 4'h0 || ovr_status !== 4'h0 || out_data !== 8'h0)
      begin bad++; $display("FAIL rst_mid: got v=%b r=%b s=%b d=%h want all 0", out_valid, ch_reading, ovr_status, out_data); end
    reset = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (ch_reading !== 4'b0001 || out_chan !== 2'd0 || out_data !== 8'h81)
      begin bad++; $display("FAIL rst_first: got r=%b c=%0d d=%h want r=0001 c=0 d=81", ch_reading, out_chan, out_data); end
    ch_ready = 4'h0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_back_to_back();
    test_overrun();
    test_enable_mask();
    test_reset_mid_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
